bcd_clock_ctrl: RTL and testbench
=================================

// Module: bcd_clock_ctrl
// PURPOSE
//  Sequencer for the 12-hour BCD clock datapath. Generates its one-second
//  enable from the system clock. Owns the user time-set mode: advances the
//  clock by bursting enable pulses (60 per minute step, 3600 per hour step),
//  so the counter datapath needs no load port. Sits between the debounced
//  button front-end and the clock; its outputs also drive the display blanking.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per run-mode enable (1 Hz at 50 MHz); >=2
//  BURST_MIN  60          enable pulses per minute-set step
//  BURST_HR   3600        enable pulses per hour-set step
//  BLINK_DIV  25_000_000  clk cycles per blink toggle in set modes; >=2
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  btn_mode   in   1   1-cycle pulse, already synchronised: cycle mode
//  btn_inc    in   1   1-cycle pulse, already synchronised: step field being set
//  clk_ena    out  1   registered enable to clock datapath (its ena input)
//  mode       out  2   0=RUN, 1=SET_HR, 2=SET_MIN (3 never driven)
//  busy       out  1   high while an enable burst is in progress
//  blink      out  1   display blank strobe for the selected field
// BEHAVIOUR
//  Reset (async, any cycle, incl. mid-burst): mode=RUN, clk_ena=0, busy=0,
//   blink=0, prescaler=0, burst count=0, blink counter=0.
//  Prescaler: counts 0..TICK_DIV-1 in RUN only; tick when count==TICK_DIV-1,
//   then wraps to 0. Held at 0 in SET_HR/SET_MIN.
//  clk_ena registered: high one cycle after tick in RUN (first pulse
//   TICK_DIV cycles after reset release or return to RUN). High every cycle
//   during a burst. Low otherwise; never high for run ticks in set modes.
//  FSM (mode states; burst is a sub-state flagged by busy):
//   RUN  --btn_mode--> SET_HR --btn_mode--> SET_MIN --btn_mode--> RUN.
//   SET_HR + btn_inc, !busy: load burst count=BURST_HR, busy=1.
//   SET_MIN + btn_inc, !busy: load burst count=BURST_MIN, busy=1.
//   Burst: each cycle clk_ena=1, count decrements; busy drops in the cycle
//   the last pulse is issued; exactly N pulses on clk_ena, back to back.
//   btn_inc in RUN: ignored.
//  Simultaneous/boundary:
//   btn_mode and btn_inc in same cycle: btn_mode wins, btn_inc dropped.
//   btn_mode while busy: ignored; burst completes in current mode.
//   btn_inc while busy: ignored (no queuing).
//   Burst count width $clog2(max(BURST_HR,BURST_MIN)+1); no wrap permitted.
//  blink: toggles every BLINK_DIV cycles in SET_HR/SET_MIN, held 1 during a
//   burst (field shown solid); forced 0 and counter cleared in RUN.
//  Datapath note: 60 pulses leave seconds unchanged; 3600 leave min+sec
//   unchanged; 12h wrap and pm toggle happen in the datapath as in run mode.
// STRUCTURE
//  Package bcd_clock_pkg: mode encoding constants (MODE_RUN/SET_HR/SET_MIN),
//   BCD widths, default TICK_DIV shared with the clock and display blocks.
//  One sub-module: clk_prescaler (parametric divider, enable + clear inputs,
//   1-cycle tick output); instantiated twice (tick, blink). FSM + burst
//   counter inline.
// TESTING  (bench uses TICK_DIV=4, BLINK_DIV=3, and the real clock datapath)
//  Reset release, idle 20 cycles -> clk_ena high for 1 cycle every 4, first
//   at cycle 4; mode=0, busy=0, blink=0.
//  btn_mode once -> mode=1, clk_ena stays 0 for 50 cycles, blink period 6.
//  SET_MIN, clock at 11:59:30 am, btn_inc -> exactly 60 consecutive clk_ena
//   pulses, busy high 60 cycles, clock reads 12:00:30 pm.
//  SET_HR, clock at 12:15:07 pm, btn_inc -> 3600 pulses, clock 01:15:07 pm;
//   btn_inc and btn_mode mid-burst -> no extra pulses, mode stays 1.
//  btn_mode+btn_inc same cycle in SET_MIN -> mode=0, no burst, run ticks
//   resume 4 cycles later.
//  Assert reset at pulse 30 of a 60-pulse burst -> clk_ena, busy drop
//   immediately (async), mode=0; no further pulses until next tick.

Source files
------------

// File: rtl/bcd_clock_pkg.sv
// bcd_clock_pkg
//  Shared definitions for the 12-hour BCD clock: the mode encoding seen on
//  the controller's mode output, BCD digit widths used by the clock and
//  display blocks, and the default divider/burst sizes.
package bcd_clock_pkg;

  // Mode encoding; value 3 is never produced.
  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  // One BCD digit; the hour tens digit only ever holds 0 or 1.
  localparam int BCD_DIGIT_W  = 4;
  localparam int HR_TENS_W    = 1;

  localparam int DEF_TICK_DIV  = 50_000_000;
  localparam int DEF_BLINK_DIV = 25_000_000;
  localparam int DEF_BURST_MIN = 60;
  localparam int DEF_BURST_HR  = 3600;

  // Larger of two integers, used to size the burst counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/bcd_clock_ctrl_prescaler.sv
// clk_prescaler
//  Parametric free-running divider. Counts 0..DIV-1 while enabled and
//  wraps; o_tick is high for the one cycle in which the count sits at DIV-1
//  and the divider is enabled. i_clr has priority and returns the count to 0.
// Ports
//  i_clk    in  1  system clock, rising edge
//  i_reset  in  1  asynchronous active-high reset
//  i_en     in  1  advance the count this cycle
//  i_clr    in  1  synchronous clear to 0 (wins over i_en)
//  o_tick   out 1  terminal-count strobe
module clk_prescaler #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));
  assign o_tick = i_en & w_last;

  // Divider count register with clear priority and wrap at DIV-1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= W'(0);
    end else if (i_clr) begin
      r_cnt <= W'(0);
    end else if (i_en) begin
      r_cnt <= w_last ? W'(0) : r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/bcd_clock_ctrl.sv
// bcd_clock_ctrl
//  Sequencer for the 12-hour BCD clock datapath. In RUN it issues one
//  clk_ena pulse every TICK_DIV cycles. In the set modes the time is advanced
//  by bursting back-to-back clk_ena pulses (BURST_HR per hour step,
//  BURST_MIN per minute step), so the datapath needs no load port. Also
//  drives the display blink strobe for the field being set.
// Ports
//  clk       in  1  system clock, rising edge
//  reset     in  1  asynchronous active-high reset, clears all state
//  btn_mode  in  1  single-cycle pulse: RUN -> SET_HR -> SET_MIN -> RUN
//  btn_inc   in  1  single-cycle pulse: step the field being set
//  clk_ena   out 1  registered enable to the clock datapath
//  mode      out 2  0=RUN, 1=SET_HR, 2=SET_MIN
//  busy      out 1  high while an enable burst is in progress
//  blink     out 1  display blank strobe for the selected field
module bcd_clock_ctrl
  import bcd_clock_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BURST_MIN = DEF_BURST_MIN,
  parameter int BURST_HR  = DEF_BURST_HR,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       clk_ena,
  output logic [1:0] mode,
  output logic       busy,
  output logic       blink
);

  localparam int CNT_W = $clog2(max_int(BURST_HR, BURST_MIN) + 1);

  mode_e            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_clk_ena;
  logic             r_blink;

  mode_e            w_mode_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_busy_next;
  logic             w_ena_next;
  logic             w_blink_next;
  logic             w_run_tick;
  logic             w_blink_tick;
  logic             w_in_run;

  assign w_in_run = (r_mode == MODE_RUN);

  // Run-mode one-second divider; held at 0 outside RUN so the first tick
  // after returning to RUN lands a full TICK_DIV cycles later.
  clk_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_div (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_in_run),
    .i_clr   (!w_in_run),
    .o_tick  (w_run_tick)
  );

  // Blink divider; runs through both set modes (and during bursts) and is
  // cleared in RUN.
  clk_prescaler #(
    .DIV (BLINK_DIV)
  ) u_blink_div (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (!w_in_run),
    .i_clr   (w_in_run),
    .o_tick  (w_blink_tick)
  );

  // Next-state logic: mode FSM, burst counter, enable and blink.
  always_comb begin
    w_mode_next  = r_mode;
    w_cnt_next   = r_cnt;
    w_busy_next  = r_busy;
    w_ena_next   = 1'b0;
    w_blink_next = r_blink;

    if (r_busy) begin
      // r_cnt counts pulses still owed including the one now on clk_ena;
      // the burst closes when the last one has been shown, so the counter
      // never decrements past zero. Buttons are ignored here.
      w_cnt_next  = r_cnt - CNT_W'(1);
      w_busy_next = (r_cnt != CNT_W'(1));
      w_ena_next  = w_busy_next;
    end else begin
      case (r_mode)
        MODE_RUN: begin
          if (btn_mode) begin
            w_mode_next = MODE_SET_HR;
          end else begin
            w_ena_next = w_run_tick;
          end
        end
        MODE_SET_HR: begin
          if (btn_mode) begin
            w_mode_next = MODE_SET_MIN;
          end else if (btn_inc) begin
            w_cnt_next  = CNT_W'(BURST_HR);
            w_busy_next = 1'b1;
            w_ena_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt;
          end
        end
        MODE_SET_MIN: begin
          if (btn_mode) begin
            w_mode_next = MODE_RUN;
          end else if (btn_inc) begin
            w_cnt_next  = CNT_W'(BURST_MIN);
            w_busy_next = 1'b1;
            w_ena_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt;
          end
        end
        default: begin
          w_mode_next = MODE_RUN;
        end
      endcase
    end

    // Field is shown solid while a burst runs; after it the blink resumes
    // from the solid state on the next divider tick.
    if (w_mode_next == MODE_RUN) begin
      w_blink_next = 1'b0;
    end else if (w_busy_next) begin
      w_blink_next = 1'b1;
    end else if (w_blink_tick) begin
      w_blink_next = ~r_blink;
    end else begin
      w_blink_next = r_blink;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode    <= MODE_RUN;
      r_cnt     <= CNT_W'(0);
      r_busy    <= 1'b0;
      r_clk_ena <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_mode    <= w_mode_next;
      r_cnt     <= w_cnt_next;
      r_busy    <= w_busy_next;
      r_clk_ena <= w_ena_next;
      r_blink   <= w_blink_next;
    end
  end

  assign clk_ena = r_clk_ena;
  assign mode    = r_mode;
  assign busy    = r_busy;
  assign blink   = r_blink;

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// tb_bcd_clock_ctrl
//  Self-checking bench for bcd_clock_ctrl with TICK_DIV=4, BLINK_DIV=3.
//  A behavioural reference of the controller and a seconds-of-day model of
//  the clock datapath (advanced on every clk_ena pulse) provide expectations.
module tb_bcd_clock_ctrl;
  import bcd_clock_pkg::*;

  localparam int TD   = 4;
  localparam int BD   = 3;
  localparam int BMIN = 60;
  localparam int BHR  = 3600;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic       clk_ena;
  logic [1:0] mode;
  logic       busy;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference controller state
  int m_mode;
  int m_left;      // pulses still owed after the one currently shown
  bit m_busy;
  bit m_ena;
  bit m_blink;
  int m_run_age;   // edges since entering RUN / reset release
  int m_set_age;   // edges since entering the set modes

  // Datapath model: seconds since midnight, advanced per clk_ena pulse
  int t_sec;
  int pulse_count;

  bcd_clock_ctrl #(
    .TICK_DIV  (TD),
    .BURST_MIN (BMIN),
    .BURST_HR  (BHR),
    .BLINK_DIV (BD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .clk_ena  (clk_ena),
    .mode     (mode),
    .busy     (busy),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         bm;
    bit         bi;
    logic [1:0] e_mode;
    logic       e_ena;
    logic       e_busy;
    logic       e_blink;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit bm, bit bi, logic [1:0] md, logic en, logic bz, logic bl);
    vec_t v;
    v.bm = bm; v.bi = bi; v.e_mode = md; v.e_ena = en; v.e_busy = bz; v.e_blink = bl;
    return v;
  endfunction

  // 12-hour BCD display value hh:mm:ss of the datapath model
  function automatic logic [6*BCD_DIGIT_W-1:0] to_bcd(int t);
    int h12, mi, s;
    h12 = (t / 3600) % 12;
    if (h12 == 0) h12 = 12;
    mi = (t / 60) % 60;
    s  = t % 60;
    return {BCD_DIGIT_W'(h12 / 10), BCD_DIGIT_W'(h12 % 10),
            BCD_DIGIT_W'(mi / 10),  BCD_DIGIT_W'(mi % 10),
            BCD_DIGIT_W'(s / 10),   BCD_DIGIT_W'(s % 10)};
  endfunction

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_mode = 0; m_left = 0; m_busy = 0; m_ena = 0; m_blink = 0;
    m_run_age = 0; m_set_age = 0;
  endtask

  // One clock edge of the reference controller with the buttons seen there.
  task model_edge(input bit bm, input bit bi);
    if (m_busy) begin
      m_set_age++;
      if (m_left > 0) begin
        m_left--;
        m_ena = 1;
      end else begin
        m_busy = 0;
        m_ena  = 0;
      end
    end else if (m_mode == 0) begin
      if (bm) begin
        m_mode    = 1;
        m_set_age = 0;
        m_ena     = 0;
      end else begin
        m_run_age++;
        m_ena = (m_run_age % TD == 0);
      end
    end else begin
      m_set_age++;
      if (bm) begin
        m_mode = (m_mode == 1) ? 2 : 0;
        if (m_mode == 0) m_run_age = 0;
      end else if (bi) begin
        m_busy = 1;
        m_left = ((m_mode == 1) ? BHR : BMIN) - 1;
      end
      m_ena = m_busy;
    end
    if (m_mode == 0) m_blink = 0;
    else if (m_busy) m_blink = 1;
    else if (m_set_age > 0 && m_set_age % BD == 0) m_blink = ~m_blink;
  endtask

  // Apply buttons for one edge, then compare against the reference.
  task step(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clk);
    model_edge(bm, bi);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    if (clk_ena === 1'b1) begin
      t_sec = (t_sec + 1) % 86400;
      pulse_count++;
    end
    check("model", {27'd0, mode, clk_ena, busy, blink},
          {27'd0, 2'(m_mode), m_ena, m_busy, m_blink});
  endtask

  task do_reset();
    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {27'd0, mode, clk_ena, busy, blink}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cyc, first_p, last_p, first_e, toggles, bad_gap, last_tog, e_cnt, guard;
    logic prev_blink;

    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    t_sec = 0; pulse_count = 0;

    tbl[0]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // Hand-derived vectors from reset release
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].bm, tbl[i].bi);
      check($sformatf("vec%0d", i), {27'd0, mode, clk_ena, busy, blink},
            {27'd0, tbl[i].e_mode, tbl[i].e_ena, tbl[i].e_busy, tbl[i].e_blink});
    end

    // SET_HR idle: no enables for 50 cycles, blink toggles every 3 cycles
    do_reset();
    step(1'b1, 1'b0);
    e_cnt = 0; toggles = 0; bad_gap = 0; last_tog = 0; prev_blink = blink;
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b0);
      if (clk_ena) e_cnt++;
      if (blink !== prev_blink) begin
        if (i - last_tog != BD) bad_gap++;
        last_tog = i;
        toggles++;
      end
      prev_blink = blink;
    end
    check("sethr_no_ena", e_cnt, 0);
    check("blink_toggles", toggles, 16);
    check("blink_gap", bad_gap, 0);

    // SET_MIN minute step from 11:59:30 am
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    t_sec = 11 * 3600 + 59 * 60 + 30;
    pulse_count = 0; busy_cyc = 0; first_p = -1; last_p = -1;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, i == 0);
      if (busy) busy_cyc++;
      if (clk_ena) begin
        if (first_p < 0) first_p = i;
        last_p = i;
      end
    end
    check("min_pulses", pulse_count, BMIN);
    check("min_busy", busy_cyc, BMIN);
    check("min_contig", last_p - first_p + 1, BMIN);
    check("min_time", to_bcd(t_sec), 24'h120030);
    check("min_pm", (t_sec / 3600) >= 12, 1);

    // SET_HR hour step from 12:15:07 pm, with inc and mode mid-burst
    do_reset();
    step(1'b1, 1'b0);
    t_sec = 12 * 3600 + 15 * 60 + 7;
    pulse_count = 0; busy_cyc = 0;
    for (int i = 0; i < 3700; i++) begin
      step(i == 200, (i == 0) || (i == 100));
      if (busy) busy_cyc++;
    end
    check("hr_pulses", pulse_count, BHR);
    check("hr_busy", busy_cyc, BHR);
    check("hr_mode", mode, 2'd1);
    check("hr_time", to_bcd(t_sec), 24'h011507);
    check("hr_pm", (t_sec / 3600) >= 12, 1);

    // mode+inc together in SET_MIN: back to RUN, ticks resume 4 cycles later
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("both_mode", mode, 2'd0);
    check("both_busy", busy, 1'b0);
    first_e = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      if (clk_ena && first_e == 0) first_e = i;
    end
    check("both_first_tick", first_e, TD);

    // Asynchronous reset in the middle of a minute burst
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    pulse_count = 0; guard = 0;
    step(1'b0, 1'b1);
    while (pulse_count < 30 && guard < 100) begin
      step(1'b0, 1'b0);
      guard++;
    end
    check("mid_pulses", pulse_count, 30);
    check("mid_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {29'd0, mode, clk_ena}, 32'd0);
    check("async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    first_e = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0);
      if (clk_ena && first_e == 0) first_e = i;
    end
    check("post_reset_tick", first_e, TD);

    // Randomised buttons against the reference
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
